// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its hazard control.
// Contents:
//   hazard_state_e   - encoding of the action taken each cycle (RUN/BUBBLE/FREEZE/FLUSH)
//   RS2_UNUSED_CODE  - Imm_extend code meaning rs2 is not read; must match forwarding_Unit
//   ctrl_t           - decoded control bundle carried through ID/EX
//   BUBBLE_*         - constants loaded into ID/EX to form a bubble
//   load_use_hazard  - load-use detection helper
package id_ex_hazard_stage_pkg;

  typedef enum logic [1:0] {
    HsRun    = 2'd0,
    HsBubble = 2'd1,
    HsFreeze = 2'd2,
    HsFlush  = 2'd3
  } hazard_state_e;

  // I-type immediate code: the instruction has no rs2 operand.
  localparam logic [4:0] RS2_UNUSED_CODE = 5'b00001;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  // A bubble is an instruction with no side effects and no register dependencies.
  localparam ctrl_t      BUBBLE_CTRL    = '0;
  localparam logic [4:0] BUBBLE_REG     = 5'd0;
  localparam logic [3:0] BUBBLE_ALU_OP  = 4'd0;
  localparam logic [4:0] BUBBLE_IMM_EXT = 5'd0;

  // A load in EX whose destination is read by the instruction in ID. x0 never
  // creates a dependency, and rs2 is ignored when the ID instruction does not use it.
  function automatic logic load_use_hazard(input logic       ex_mem_read,
                                           input logic [4:0] ex_rd,
                                           input logic [4:0] id_rs1,
                                           input logic [4:0] id_rs2,
                                           input logic [4:0] id_imm_extend,
                                           input logic [4:0] rs2_unused);
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && (id_imm_extend != rs2_unused)));
  endfunction

endpackage

// File: rtl/id_ex_hazard_stage_sat_counter.sv
// Saturating up-counter used for stall/flush performance statistics.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset, clears the count
//   clear  - synchronous clear
//   inc    - increment by one this cycle (ignored once the count is all-ones)
//   count  - current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use, branch-flush and memory-freeze control.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   id_*                - decoded instruction fields and operands from ID
//   ex_branch_taken     - branch resolved taken in EX this cycle
//   mem_busy            - data memory not ready; whole pipeline holds
//   ex_*                - registered ID/EX contents (to EX and forwarding_Unit)
//   pc_write            - PC may update this cycle (combinational)
//   if_id_write         - IF/ID may load this cycle (combinational)
//   if_id_flush         - IF/ID must load a NOP this cycle (combinational)
//   hazard_state        - action taken in the previous cycle
//   stall_cnt/flush_cnt - saturating event counters
module id_ex_hazard_stage
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CNT_W      = 16,
  parameter logic [4:0]  RS2_UNUSED = RS2_UNUSED_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_Branch,
  input  logic [3:0]       id_ALUOp,
  input  logic [4:0]       id_Imm_extend,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_Branch,
  output logic [3:0]       ex_ALUOp,
  output logic [4:0]       ex_Imm_extend,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // ID/EX register contents
  logic [4:0]      ex_rs1_d, ex_rs1_q;
  logic [4:0]      ex_rs2_d, ex_rs2_q;
  logic [4:0]      ex_rd_d, ex_rd_q;
  ctrl_t           ex_ctrl_d, ex_ctrl_q;
  logic [3:0]      ex_alu_op_d, ex_alu_op_q;
  logic [4:0]      ex_imm_ext_d, ex_imm_ext_q;
  logic [XLEN-1:0] ex_rdata1_d, ex_rdata1_q;
  logic [XLEN-1:0] ex_rdata2_d, ex_rdata2_q;
  logic [XLEN-1:0] ex_imm_d, ex_imm_q;
  logic [XLEN-1:0] ex_pc_d, ex_pc_q;

  hazard_state_e   hazard_state_d, hazard_state_q;
  hazard_state_e   action;
  logic            load_use;
  logic            stall_inc, flush_inc;
  ctrl_t           id_ctrl;

  assign id_ctrl = '{reg_write:  id_RegWrite,
                     mem_to_reg: id_MemtoReg,
                     mem_read:   id_MemRead,
                     mem_write:  id_MemWrite,
                     branch:     id_Branch};

  // Hazard detection looks at the registered EX instruction and the one in ID.
  always_comb begin
    load_use = load_use_hazard(ex_ctrl_q.mem_read, ex_rd_q, id_rs1, id_rs2,
                               id_Imm_extend, RS2_UNUSED);
    // Priority: freeze > flush > bubble > run. A taken branch is left pending
    // during a freeze since EX is held and it re-presents once memory is ready.
    if (mem_busy) begin
      action = HsFreeze;
    end else if (ex_branch_taken) begin
      action = HsFlush;
    end else if (load_use) begin
      action = HsBubble;
    end else begin
      action = HsRun;
    end
  end

  // Next-state of the ID/EX register.
  always_comb begin
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_alu_op_d  = ex_alu_op_q;
    ex_imm_ext_d = ex_imm_ext_q;
    ex_rdata1_d  = ex_rdata1_q;
    ex_rdata2_d  = ex_rdata2_q;
    ex_imm_d     = ex_imm_q;
    ex_pc_d      = ex_pc_q;
    unique case (action)
      HsFreeze: ;
      HsFlush, HsBubble: begin
        ex_rs1_d     = BUBBLE_REG;
        ex_rs2_d     = BUBBLE_REG;
        ex_rd_d      = BUBBLE_REG;
        ex_ctrl_d    = BUBBLE_CTRL;
        ex_alu_op_d  = BUBBLE_ALU_OP;
        ex_imm_ext_d = BUBBLE_IMM_EXT;
        ex_rdata1_d  = '0;
        ex_rdata2_d  = '0;
        ex_imm_d     = '0;
        ex_pc_d      = '0;
      end
      HsRun: begin
        ex_rs1_d     = id_rs1;
        ex_rs2_d     = id_rs2;
        ex_rd_d      = id_rd;
        ex_ctrl_d    = id_ctrl;
        ex_alu_op_d  = id_ALUOp;
        ex_imm_ext_d = id_Imm_extend;
        ex_rdata1_d  = id_rdata1;
        ex_rdata2_d  = id_rdata2;
        ex_imm_d     = id_imm;
        ex_pc_d      = id_pc;
      end
      default: ;
    endcase
  end

  // Front-end control and statistics; nothing advances while reset is held.
  always_comb begin
    hazard_state_d = action;
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    if_id_flush    = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (!reset) begin
      unique case (action)
        HsFreeze: stall_inc = 1'b1;
        HsBubble: stall_inc = 1'b1;
        HsFlush: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
        end
        HsRun: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs1_q       <= BUBBLE_REG;
      ex_rs2_q       <= BUBBLE_REG;
      ex_rd_q        <= BUBBLE_REG;
      ex_ctrl_q      <= BUBBLE_CTRL;
      ex_alu_op_q    <= BUBBLE_ALU_OP;
      ex_imm_ext_q   <= BUBBLE_IMM_EXT;
      ex_rdata1_q    <= '0;
      ex_rdata2_q    <= '0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      hazard_state_q <= HsRun;
    end else begin
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_imm_ext_q   <= ex_imm_ext_d;
      ex_rdata1_q    <= ex_rdata1_d;
      ex_rdata2_q    <= ex_rdata2_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      hazard_state_q <= hazard_state_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

  assign ex_rs1        = ex_rs1_q;
  assign ex_rs2        = ex_rs2_q;
  assign ex_rd         = ex_rd_q;
  assign ex_RegWrite   = ex_ctrl_q.reg_write;
  assign ex_MemtoReg   = ex_ctrl_q.mem_to_reg;
  assign ex_MemRead    = ex_ctrl_q.mem_read;
  assign ex_MemWrite   = ex_ctrl_q.mem_write;
  assign ex_Branch     = ex_ctrl_q.branch;
  assign ex_ALUOp      = ex_alu_op_q;
  assign ex_Imm_extend = ex_imm_ext_q;
  assign ex_rdata1     = ex_rdata1_q;
  assign ex_rdata2     = ex_rdata2_q;
  assign ex_imm        = ex_imm_q;
  assign ex_pc         = ex_pc_q;
  assign hazard_state  = hazard_state_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: a behavioural reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations. A second
// instance with 2-bit counters exercises counter saturation.
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic        mr;
    logic        mw;
    logic        br;
    logic [3:0]  alu;
    logic [4:0]  immx;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  logic        clk, reset;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_Imm_extend;
  logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch;
  logic [3:0]  id_ALUOp;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic        ex_branch_taken, mem_busy;

  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_Imm_extend;
  logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch;
  logic [3:0]  ex_ALUOp;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic        pc_write, if_id_write, if_id_flush;
  logic [1:0]  hazard_state;
  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0]  s_rs1, s_rs2, s_rd, s_Imm_extend;
  logic        s_RegWrite, s_MemtoReg, s_MemRead, s_MemWrite, s_Branch;
  logic [3:0]  s_ALUOp;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc;
  logic        s_pc_write, s_if_id_write, s_if_id_flush;
  logic [1:0]  s_hazard_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int fails = 0;

  id_ex_hazard_stage #(.XLEN(32), .CNT_W(16), .RS2_UNUSED(5'b00001)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
    .id_Imm_extend(id_Imm_extend), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_pc(id_pc), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .ex_Imm_extend(ex_Imm_extend),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .hazard_state(hazard_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_hazard_stage #(.XLEN(32), .CNT_W(2), .RS2_UNUSED(5'b00001)) dut_small (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
    .id_Imm_extend(id_Imm_extend), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_pc(id_pc), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_RegWrite(s_RegWrite),
    .ex_MemtoReg(s_MemtoReg), .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite),
    .ex_Branch(s_Branch), .ex_ALUOp(s_ALUOp), .ex_Imm_extend(s_Imm_extend),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc(s_pc),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .hazard_state(s_hazard_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  ex_t id_pack, dut_ex, small_ex;
  assign id_pack  = {id_rs1, id_rs2, id_rd, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite,
                     id_Branch, id_ALUOp, id_Imm_extend, id_rdata1, id_rdata2, id_imm, id_pc};
  assign dut_ex   = {ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
                     ex_Branch, ex_ALUOp, ex_Imm_extend, ex_rdata1, ex_rdata2, ex_imm, ex_pc};
  assign small_ex = {s_rs1, s_rs2, s_rd, s_RegWrite, s_MemtoReg, s_MemRead, s_MemWrite,
                     s_Branch, s_ALUOp, s_Imm_extend, s_rdata1, s_rdata2, s_imm, s_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Actions: 0 run, 1 bubble, 2 freeze, 3 flush.
  ex_t m_ex;
  int  m_hs, m_stall, m_flush, m_stall2, m_flush2;
  bit  model_live = 0;

  function automatic int exp_action();
    bit lu;
    lu = m_ex.mr && (m_ex.rd != 0) &&
         ((m_ex.rd == id_rs1) || ((m_ex.rd == id_rs2) && (id_Imm_extend != 5'b00001)));
    if (mem_busy) return 2;
    if (ex_branch_taken) return 3;
    if (lu) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int act;
    if (reset) begin
      m_ex = '0; m_hs = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
      model_live = 1;
    end else if (model_live) begin
      act = exp_action();
      if (act == 0) m_ex = id_pack;
      else if (act != 2) m_ex = '0;
      if (act == 1 || act == 2) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
      if (act == 3) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush2 < 3) m_flush2++;
      end
      m_hs = act;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    int act;
    if (model_live) begin
      check("ex_regs", 160'(dut_ex), 160'(m_ex));
      check("ex_regs_small", 160'(small_ex), 160'(m_ex));
      check("hazard_state", 160'(hazard_state), 160'(m_hs));
      check("stall_cnt", 160'(stall_cnt), 160'(m_stall));
      check("flush_cnt", 160'(flush_cnt), 160'(m_flush));
      check("stall_cnt_small", 160'(s_stall_cnt), 160'(m_stall2));
      check("flush_cnt_small", 160'(s_flush_cnt), 160'(m_flush2));
      if (!reset) begin
        act = exp_action();
        check("pc_write", 160'(pc_write), 160'(act == 0 || act == 3));
        check("if_id_write", 160'(if_id_write), 160'(act == 0 || act == 3));
        check("if_id_flush", 160'(if_id_flush), 160'(act == 3));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic [4:0] immx, input logic bt, input logic busy);
    logic [31:0] r;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_Imm_extend = immx;
    id_RegWrite = 1'b1; id_MemtoReg = mr; id_MemRead = mr; id_MemWrite = 1'b0;
    r = $urandom; id_Branch = r[4]; id_ALUOp = r[3:0];
    id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc = $urandom;
    ex_branch_taken = bt; mem_busy = busy;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    r = $urandom;
    put(r[4:0], r[9:5], r[14:10], r[15], r[20:16], r[21], r[22]);
    tick();
    tick();
    reset = 1'b0;
    check("rst_ex_rs1", 160'(ex_rs1), 160'(0));
    check("rst_ex_MemRead", 160'(ex_MemRead), 160'(0));
    check("rst_ex_pc", 160'(ex_pc), 160'(0));
    check("rst_hazard_state", 160'(hazard_state), 160'(0));
    check("rst_stall_cnt", 160'(stall_cnt), 160'(0));
    check("rst_flush_cnt", 160'(flush_cnt), 160'(0));

    // Load-use on rs1.
    put(5'd1, 5'd2, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd5, 5'd2, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("lu_rs1_pc_write", 160'(pc_write), 160'(0));
    check("lu_rs1_if_id_write", 160'(if_id_write), 160'(0));
    tick();
    check("lu_rs1_hazard_state", 160'(hazard_state), 160'(1));
    check("lu_rs1_stall_cnt", 160'(stall_cnt), 160'(1));
    check("lu_rs1_bubble_rd", 160'(ex_rd), 160'(0));
    check("lu_rs1_bubble_MemRead", 160'(ex_MemRead), 160'(0));
    #1;
    check("lu_rs1_after_pc_write", 160'(pc_write), 160'(1));
    tick();
    check("lu_rs1_pass_ex_rs1", 160'(ex_rs1), 160'(5));
    check("lu_rs1_pass_state", 160'(hazard_state), 160'(0));

    // rs2 ignored for I-type, honoured otherwise.
    put(5'd1, 5'd2, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd3, 5'd7, 5'd8, 1'b0, 5'b00001, 1'b0, 1'b0);
    #1;
    check("rs2_unused_pc_write", 160'(pc_write), 160'(1));
    tick();
    check("rs2_unused_state", 160'(hazard_state), 160'(0));
    check("rs2_unused_ex_rs2", 160'(ex_rs2), 160'(7));
    check("rs2_unused_stall_cnt", 160'(stall_cnt), 160'(1));
    put(5'd1, 5'd2, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd3, 5'd7, 5'd8, 1'b0, 5'b00000, 1'b0, 1'b0);
    #1;
    check("rs2_used_pc_write", 160'(pc_write), 160'(0));
    tick();
    check("rs2_used_state", 160'(hazard_state), 160'(1));
    check("rs2_used_stall_cnt", 160'(stall_cnt), 160'(2));
    tick();

    // Load to x0 and a non-load producer never stall.
    put(5'd1, 5'd2, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("x0_pc_write", 160'(pc_write), 160'(1));
    tick();
    check("x0_state", 160'(hazard_state), 160'(0));
    put(5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd5, 5'd2, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("nonload_pc_write", 160'(pc_write), 160'(1));
    tick();
    check("nonload_state", 160'(hazard_state), 160'(0));

    // Branch flush overrides a coincident load-use.
    put(5'd1, 5'd2, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd5, 5'd2, 5'd6, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    check("flush_if_id_flush", 160'(if_id_flush), 160'(1));
    check("flush_pc_write", 160'(pc_write), 160'(1));
    tick();
    check("flush_state", 160'(hazard_state), 160'(3));
    check("flush_flush_cnt", 160'(flush_cnt), 160'(1));
    check("flush_stall_cnt", 160'(stall_cnt), 160'(2));
    check("flush_bubble_RegWrite", 160'(ex_RegWrite), 160'(0));

    // Freeze for 3 cycles with a pending branch, then the flush takes effect.
    put(5'd1, 5'd2, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    put(5'd4, 5'd9, 5'd10, 1'b1, 5'd0, 1'b1, 1'b1);
    #1;
    check("freeze_pc_write", 160'(pc_write), 160'(0));
    check("freeze_if_id_flush", 160'(if_id_flush), 160'(0));
    tick();
    tick();
    tick();
    check("freeze_held_rd", 160'(ex_rd), 160'(9));
    check("freeze_state", 160'(hazard_state), 160'(2));
    check("freeze_stall_cnt", 160'(stall_cnt), 160'(5));
    check("freeze_stall_small_sat", 160'(s_stall_cnt), 160'(3));
    mem_busy = 1'b0;
    #1;
    check("release_if_id_flush", 160'(if_id_flush), 160'(1));
    tick();
    check("release_state", 160'(hazard_state), 160'(3));
    check("release_flush_cnt", 160'(flush_cnt), 160'(2));

    // Small counter stays saturated.
    put(5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    tick();
    check("sat_hold_small", 160'(s_stall_cnt), 160'(3));
    check("sat_big_cnt", 160'(stall_cnt), 160'(7));

    // Reset during a freeze wins.
    reset = 1'b1;
    tick();
    check("rst_mid_freeze_state", 160'(hazard_state), 160'(0));
    check("rst_mid_freeze_stall", 160'(stall_cnt), 160'(0));
    check("rst_mid_freeze_flush", 160'(flush_cnt), 160'(0));
    reset = 1'b0;
    mem_busy = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated hazard control for the 5-stage RISC-V core. It sits directly upstream of forwarding_Unit.
- Its registered ex_rs1, ex_rs2 and ex_Imm_extend feed the forwarding unit's rs1, rs2 and Imm_extend inputs.
- Detects load-use hazards and inserts one bubble. Handles branch-taken flushes and whole-pipeline freeze while data memory is busy.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of the stall and flush counters.
- RS2_UNUSED, 5'b00001, Imm_extend code meaning rs2 is not read (I-type). Must match the code used by forwarding_Unit.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2, id_rd  in  5 each  register indices from decode.
- id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch  in  1 each  decoded controls.
- id_ALUOp  in  4  ALU operation.
- id_Imm_extend  in  5  immediate-format code.
- id_rdata1, id_rdata2, id_imm, id_pc  in  XLEN each  operands, immediate and PC.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp, ex_Imm_extend, ex_rdata1, ex_rdata2, ex_imm, ex_pc  out  same widths as the id_ inputs  registered ID/EX contents.
- pc_write  out  1  PC may update this cycle.
- if_id_write  out  1  IF/ID register may load this cycle.
- if_id_flush  out  1  IF/ID register must load a NOP this cycle.
- hazard_state  out  2  action taken last cycle: RUN=0, BUBBLE=1, FREEZE=2, FLUSH=3.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (synchronous):
  - All ex_* outputs are 0, which is a bubble.
  - hazard_state=RUN; both counters are 0.
- Combinational hazard detection (all inputs and current registered outputs):
  - load_use = ex_MemRead && ex_rd!=0 && (ex_rd==id_rs1 || (ex_rd==id_rs2 && id_Imm_extend!=RS2_UNUSED)).
- Action per cycle, first matching row wins:
  - 1. reset: as above.
  - 2. FREEZE (mem_busy=1): hold all ex_* registers. pc_write=0, if_id_write=0, if_id_flush=0. stall_cnt++. ex_branch_taken is ignored here because EX is held, so the branch stays asserted and is handled once mem_busy drops.
  - 3. FLUSH (ex_branch_taken=1): load a bubble into ID/EX. pc_write=1 (redirect), if_id_write=1, if_id_flush=1. flush_cnt++. This overrides load_use, because the dependent instruction is squashed anyway.
  - 4. BUBBLE (load_use=1): load a bubble into ID/EX. pc_write=0, if_id_write=0, if_id_flush=0. stall_cnt++.
  - 5. RUN: load all id_* into ex_*. pc_write=1, if_id_write=1, if_id_flush=0.
- Bubble definition:
  - ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch are 0.
  - ex_rd, ex_rs1, ex_rs2, ex_ALUOp, ex_Imm_extend are 0.
  - Data fields (rdata, imm, pc) are don't-care; they are cleared to 0.
- Output timing:
  - pc_write, if_id_write and if_id_flush are combinational, valid in the same cycle as the decision.
  - hazard_state is registered and records the action taken, one cycle later.
- Load-use latency: exactly one bubble per load-use pair. The cycle after BUBBLE, load_use is necessarily 0 because ex_MemRead=0.
- Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap). Only reset clears them.
- Register x0: a load with rd=0 never stalls.
- Reset asserted mid-FREEZE or mid-BUBBLE: reset wins in that cycle and no hazard action is recorded.

Decomposition:
- Shared package holds:
  - The hazard_state encodings RUN, BUBBLE, FREEZE, FLUSH.
  - The RS2_UNUSED Imm_extend code, shared with forwarding_Unit.
  - The bubble control constants.
- One natural sub-module: sat_counter (width CNT_W, inc, clear), instantiated twice.

Test Plan:
- Reset: assert reset with random inputs for 2 cycles -> all ex_*=0, hazard_state=0, stall_cnt=flush_cnt=0.
- Load-use on rs1: ex_MemRead=1, ex_rd=5; next id_rs1=5, id_Imm_extend=0 -> pc_write=0, if_id_write=0, ID/EX bubble, hazard_state=1, stall_cnt=1. The following cycle the instruction passes with ex_rs1=5.
- Load-use skipped for rs2: ex_rd=7, id_rs2=7, id_rs1=3, id_Imm_extend=5'b00001 -> RUN with no stall. The same case with id_Imm_extend=5'b00000 -> BUBBLE.
- x0 and non-load: ex_MemRead=1, ex_rd=0, id_rs1=0 -> RUN. ex_MemRead=0, ex_rd=5, id_rs1=5 -> RUN (forwarding handles it).
- Branch flush with coincident load_use: ex_branch_taken=1 -> if_id_flush=1, pc_write=1, ID/EX bubble, hazard_state=3, flush_cnt=1, stall_cnt unchanged.
- Freeze then saturation: mem_busy=1 for 3 cycles with ex_branch_taken=1 -> ex_* held, pc_write=0, stall_cnt=3; on release -> FLUSH. With CNT_W=2, run 5 stall cycles -> stall_cnt=3 and holds.
